// File: rtl/tinyalu_core_if.sv
// tinyalu_core_if: operand/start/done bus between the TinyALU initiator (BFM)
// and the ALU responder.
//   A, B    : 8-bit unsigned operands
//   op      : 3-bit opcode (000 no_op, 001 add, 010 and, 011 xor, 100 mul)
//   start   : request, held high by the initiator until done is seen
//   done    : one-cycle completion pulse from the responder
//   result  : 16-bit result, valid while done=1
// Modports: master = initiator side, slave = ALU side.
interface tinyalu_core_if;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  op;
  logic        start;
  logic        done;
  logic [15:0] result;

  modport master (
    output A, B, op, start,
    input  done, result
  );

  modport slave (
    input  A, B, op, start,
    output done, result
  );
endinterface

// File: rtl/tinyalu_core.sv
// tinyalu_core: TinyALU datapath, responder end of the operand/start/done
// handshake. add/and/xor complete at the capture edge; mul completes
// MUL_LATENCY posedges after capture (capture edge counted as 1).
// Ports:
//   clk      : clock, all state updates on posedge
//   reset_n  : asynchronous active-low reset
//   bus      : tinyalu_core_if.slave (A, B, op, start in; done, result out)
// Parameters:
//   MUL_LATENCY : 1..8, edges from capture to done for mul
module tinyalu_core #(
  parameter int MUL_LATENCY = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  tinyalu_core_if.slave  bus
);

  localparam logic [1:0] ST_IDLE         = 2'd0;
  localparam logic [1:0] ST_MUL_BUSY     = 2'd1;
  localparam logic [1:0] ST_WAIT_RELEASE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  localparam logic [3:0] CNT_LOAD = 4'(MUL_LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic        done_q, done_d;
  logic [15:0] result_q, result_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    done_d   = 1'b0;
    result_d = result_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          case (bus.op)
            OP_ADD: begin
              result_d = {7'b0, ({1'b0, bus.A} + {1'b0, bus.B})};
              done_d   = 1'b1;
              state_d  = ST_WAIT_RELEASE;
            end
            OP_AND: begin
              result_d = {8'b0, (bus.A & bus.B)};
              done_d   = 1'b1;
              state_d  = ST_WAIT_RELEASE;
            end
            OP_XOR: begin
              result_d = {8'b0, (bus.A ^ bus.B)};
              done_d   = 1'b1;
              state_d  = ST_WAIT_RELEASE;
            end
            OP_MUL: begin
              a_d   = bus.A;
              b_d   = bus.B;
              cnt_d = CNT_LOAD;
              if (MUL_LATENCY == 1) begin
                // Degenerate case: product is produced at the capture edge.
                result_d = 16'(bus.A) * 16'(bus.B);
                done_d   = 1'b1;
                state_d  = ST_WAIT_RELEASE;
              end else begin
                state_d = ST_MUL_BUSY;
              end
            end
            default: begin
              // no_op and unused opcodes are silently ignored.
            end
          endcase
        end
      end

      ST_MUL_BUSY: begin
        // Bus inputs are ignored here; only the latched operands matter,
        // and the op completes even if start drops.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          result_d = 16'(a_q) * 16'(b_q);
          done_d   = 1'b1;
          state_d  = ST_WAIT_RELEASE;
        end
      end

      ST_WAIT_RELEASE: begin
        // The edge that sees start low returns to IDLE without capturing.
        if (!bus.start) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      a_q      <= 8'd0;
      b_q      <= 8'd0;
      done_q   <= 1'b0;
      result_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign bus.done   = done_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_tinyalu_core.sv
module tb_tinyalu_core;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;

  tinyalu_core_if bus ();

  tinyalu_core #(.MUL_LATENCY(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sample point: 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 8'd0;
    bus.B     = 8'd0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 16'h0000) begin
      errors++;
      $display("FAIL reset_assert: done=%b result=%h expected done=0 result=0000", bus.done, bus.result);
    end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.result !== 16'h0000) begin
        errors++;
        $display("FAIL reset_idle[%0d]: done=%b result=%h expected done=0 result=0000", i, bus.done, bus.result);
      end
    end
    $display("reset: idle 5 cycles done=%b result=%h", bus.done, bus.result);
  endtask

  task automatic test_add();
    @(negedge clk);
    bus.A = 8'hFF; bus.B = 8'h01; bus.op = 3'b001; bus.start = 1'b1;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 16'h0100) begin
      errors++;
      $display("FAIL add_ff_01: done=%b result=%h expected done=1 result=0100", bus.done, bus.result);
    end
    @(negedge clk);
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 16'h0100) begin
      errors++;
      $display("FAIL add_hold: done=%b result=%h expected done=0 result=0100", bus.done, bus.result);
    end
    $display("add A=ff B=01 result=%h", bus.result);
  endtask

  // and then xor back to back, one WAIT_RELEASE cycle between them.
  task automatic test_back_to_back();
    logic [2:0]  op_v;
    logic [15:0] exp_v;
    for (int i = 0; i < 2; i++) begin
      op_v  = (i == 0) ? 3'b010 : 3'b011;
      exp_v = (i == 0) ? 16'h0030 : 16'h00CC;
      @(negedge clk);
      bus.A = 8'hF0; bus.B = 8'h3C; bus.op = op_v; bus.start = 1'b1;
      tick();
      checks++;
      if (bus.done !== 1'b1 || bus.result !== exp_v) begin
        errors++;
        $display("FAIL b2b_op%0d: done=%b result=%h expected done=1 result=%h", op_v, bus.done, bus.result, exp_v);
      end
      @(negedge clk);
      bus.start = 1'b0;
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.result !== exp_v) begin
        errors++;
        $display("FAIL b2b_release_op%0d: done=%b result=%h expected done=0 result=%h", op_v, bus.done, bus.result, exp_v);
      end
      $display("op=%0d A=f0 B=3c result=%h", op_v, bus.result);
    end
  endtask

  // Holding start high after done must not start a second operation.
  task automatic test_hold_start();
    @(negedge clk);
    bus.A = 8'h01; bus.B = 8'h01; bus.op = 3'b001; bus.start = 1'b1;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 16'h0002) begin
      errors++;
      $display("FAIL hold_first: done=%b result=%h expected done=1 result=0002", bus.done, bus.result);
    end
    @(negedge clk);
    bus.A = 8'h07; bus.B = 8'h08;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.result !== 16'h0002) begin
        errors++;
        $display("FAIL hold_no_recapture[%0d]: done=%b result=%h expected done=0 result=0002", i, bus.done, bus.result);
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    tick();
    $display("hold start: result=%h", bus.result);
  endtask

  task automatic test_mul();
    // 0xFF*0xFF with A changed during MUL_BUSY
    @(negedge clk);
    bus.A = 8'hFF; bus.B = 8'hFF; bus.op = 3'b100; bus.start = 1'b1;
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mul_edge1: done=%b expected done=0", bus.done);
    end
    @(negedge clk);
    bus.A = 8'h00;
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mul_edge2: done=%b expected done=0", bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 16'hFE01) begin
      errors++;
      $display("FAIL mul_ff_ff: done=%b result=%h expected done=1 result=fe01", bus.done, bus.result);
    end
    @(negedge clk);
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 16'hFE01) begin
      errors++;
      $display("FAIL mul_hold: done=%b result=%h expected done=0 result=fe01", bus.done, bus.result);
    end
    $display("mul A=ff B=ff result=%h", bus.result);

    // 0x12*0x34 = 0x03A8 with start dropped right after capture
    @(negedge clk);
    bus.A = 8'h12; bus.B = 8'h34; bus.op = 3'b100; bus.start = 1'b1;
    tick();
    @(negedge clk);
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mul_drop_edge2: done=%b expected done=0", bus.done);
    end
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 16'h03A8) begin
      errors++;
      $display("FAIL mul_drop_start: done=%b result=%h expected done=1 result=03a8", bus.done, bus.result);
    end
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mul_drop_pulse: done=%b expected done=0", bus.done);
    end
    $display("mul A=12 B=34 start dropped result=%h", bus.result);
  endtask

  task automatic test_noop_and_async_reset();
    logic [2:0] op_v;
    for (int i = 0; i < 4; i++) begin
      op_v = (i == 0) ? 3'b000 : 3'(4 + i);
      @(negedge clk);
      bus.A = 8'h05; bus.B = 8'h05; bus.op = op_v; bus.start = 1'b1;
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.result !== 16'h03A8) begin
        errors++;
        $display("FAIL ignored_op%0d: done=%b result=%h expected done=0 result=03a8", op_v, bus.done, bus.result);
      end
      @(negedge clk);
      bus.start = 1'b0;
      tick();
      $display("ignored op=%0d result=%h", op_v, bus.result);
    end
    // rst_op: reset pulsed mid-cycle clears outputs without waiting for an edge
    @(negedge clk);
    bus.op = 3'b111; bus.start = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.done !== 1'b0 || bus.result !== 16'h0000) begin
      errors++;
      $display("FAIL async_reset: done=%b result=%h expected done=0 result=0000", bus.done, bus.result);
    end
    @(negedge clk);
    reset_n = 1'b1;
    $display("rst_op: result=%h", bus.result);
  endtask

  task automatic test_reset_mid_mul();
    // leave a nonzero result first so the reset clear is observable
    @(negedge clk);
    bus.A = 8'h11; bus.B = 8'h22; bus.op = 3'b011; bus.start = 1'b1;
    tick();
    @(negedge clk);
    bus.start = 1'b0;
    tick();
    @(negedge clk);
    bus.A = 8'h10; bus.B = 8'h10; bus.op = 3'b100; bus.start = 1'b1;
    tick();
    @(negedge clk);
    reset_n = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.result !== 16'h0000) begin
        errors++;
        $display("FAIL mid_mul_reset[%0d]: done=%b result=%h expected done=0 result=0000", i, bus.done, bus.result);
      end
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.done !== 1'b0 || bus.result !== 16'h0000) begin
        errors++;
        $display("FAIL aborted_mul[%0d]: done=%b result=%h expected done=0 result=0000", i, bus.done, bus.result);
      end
    end
    @(negedge clk);
    bus.A = 8'h02; bus.B = 8'h03; bus.op = 3'b001; bus.start = 1'b1;
    tick();
    checks++;
    if (bus.done !== 1'b1 || bus.result !== 16'h0005) begin
      errors++;
      $display("FAIL add_after_reset: done=%b result=%h expected done=1 result=0005", bus.done, bus.result);
    end
    @(negedge clk);
    bus.start = 1'b0;
    tick();
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL add_after_reset_pulse: done=%b expected done=0", bus.done);
    end
    $display("reset mid-mul, then add A=02 B=03 result=%h", bus.result);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_add();
    test_back_to_back();
    test_hold_start();
    test_mul();
    test_noop_and_async_reset();
    test_reset_mid_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tinyalu_core.md
Name: tinyalu_core

Overview:
- Responder end of the TinyALU operand/start/done handshake: the ALU datapath that the testbench BFM drives.
- Samples A, B and op on start and executes add/and/xor in one cycle, mul over a multi-cycle path.
- Returns a registered 16-bit result qualified by a one-cycle done pulse.
- Top-level DUT of the chapter benches; connects directly to the BFM interface signals.

Parameters:
- MUL_LATENCY, 3, posedges from the capture edge to the edge where done rises for mul, capture edge counted as 1; legal range 1..8.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- op  input  3  opcode: 000 no_op, 001 add, 010 and, 011 xor, 100 mul; 101/110/111 unused, 111 used as rst_op by the driver.
- start  input  1  operation request; held high by the initiator until done is seen.
- done  output  1  one-cycle completion pulse, registered.
- result  output  16  operation result, registered; valid while done=1.

Behaviour:
- Reset: reset_n low asynchronously forces done=0, result=16'h0000, state=IDLE, mul counter=0 and operand latches=0.
- Reset takes effect immediately, including mid-mul; an aborted mul never produces done.
- FSM states: IDLE, MUL_BUSY, WAIT_RELEASE.
- IDLE, start=1, op in {add, and, xor}, at that posedge (capture edge):
  - add: result <= {7'b0, A+B}, 9-bit sum zero-extended.
  - and: result <= {8'b0, A&B}.
  - xor: result <= {8'b0, A^B}.
  - done <= 1; next state WAIT_RELEASE. Latency is 1 (done rises at the capture edge).
- IDLE, start=1, op=mul:
  - Latch A and B; load counter with MUL_LATENCY-1.
  - If MUL_LATENCY=1: behave as a single-cycle op with result <= A*B (full 16-bit product).
  - Otherwise: next state MUL_BUSY.
- MUL_BUSY: counter decrements each posedge. At the edge where counter==1: result <= latched A * latched B, done <= 1, next state WAIT_RELEASE.
  - A, B, op and start changes during MUL_BUSY are ignored.
  - If start drops during MUL_BUSY, the op still completes and done still pulses.
- IDLE, start=1, op in {no_op, 101, 110, 111}: no done, result unchanged, stay IDLE.
- IDLE, start=0: no change.
- WAIT_RELEASE: done <= 0 at the next posedge; go to IDLE only at a posedge that samples start=0.
  - No new operation is accepted until start has been sampled low once after done.
  - The edge that samples start=0 never captures.
- done is high for exactly one clock per accepted add/and/xor/mul and is 0 on every other edge.
- result holds its value until the next completing operation; it is never cleared except by reset.
- Driver timing compatibility: inputs change on negedge; start drops at the negedge where done=1 is seen, so WAIT_RELEASE lasts one cycle.

Test Plan:
- Reset then idle: reset_n low 2 cycles, start=0 for 5 cycles -> done=0, result=0x0000 throughout.
- add A=0xFF B=0x01 start at negedge -> done=1 on the next posedge for one cycle, result=0x0100; after start drops, done=0 and result holds 0x0100.
- and A=0xF0 B=0x3C -> result=0x0030; xor A=0xF0 B=0x3C -> result=0x00CC. Each has latency 1 and back-to-back ops are separated by one WAIT_RELEASE cycle.
- mul A=0xFF B=0xFF, MUL_LATENCY=3 -> done rises at the 3rd posedge counting the capture edge, result=0xFE01. Changing A to 0x00 during MUL_BUSY does not change the result.
- no_op with start pulsed for one edge -> no done, result unchanged. Then op=111 with start=0 and reset_n pulsed low mid-cycle -> result=0, done=0 immediately.
- Reset mid-mul: mul 0x10*0x10 started, reset_n low after 1 edge -> no done pulse and result=0. Next add 0x02+0x03 -> result=0x0005 with latency 1.
